// File: rtl/ddr4_cmd_monitor.sv
// Passive DDR4 command-bus monitor: decodes commands, tracks bank state,
// checks CA parity, bank legality and tRCD, and keeps counters and sticky errors.
module ddr4_cmd_monitor #(
    parameter int CNT_W = 32,
    parameter int TRCD  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dimm_rst_n,
    input  logic             cke,
    input  logic             cs_n,
    input  logic             act_n,
    input  logic [16:0]      ma,
    input  logic [1:0]       ba,
    input  logic [1:0]       bg,
    input  logic             par,
    output logic             cmd_valid,
    output logic [2:0]       cmd_code,
    output logic [3:0]       cmd_bank,
    output logic [15:0]      bank_open,
    output logic [CNT_W-1:0] cnt_act,
    output logic [CNT_W-1:0] cnt_rd,
    output logic [CNT_W-1:0] cnt_wr,
    output logic [CNT_W-1:0] cnt_pre,
    output logic [CNT_W-1:0] cnt_ref,
    output logic [4:0]       err_flags,
    output logic [2:0]       first_err_code,
    output logic [3:0]       first_err_bank,
    output logic             first_err_valid
);

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_ACT   = 3'd1;
    localparam logic [2:0] C_RD    = 3'd2;
    localparam logic [2:0] C_WR    = 3'd3;
    localparam logic [2:0] C_PRE   = 3'd4;
    localparam logic [2:0] C_REF   = 3'd5;
    localparam logic [2:0] C_MRS   = 3'd6;
    localparam logic [2:0] C_OTHER = 3'd7;

    localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(TRCD - 1);

    logic          active;
    logic [2:0]    code;
    logic [3:0]    bank;
    logic          is_rw;
    logic          par_err;
    logic [4:0]    err_new;
    logic [15:0]   open_nxt;
    logic [TW-1:0] timer     [16];
    logic [TW-1:0] timer_nxt [16];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // rst_n is handled by the register reset branch, so it is not part of this term
    assign active = dimm_rst_n & cke & ~cs_n;
    assign bank   = {bg, ba};

    always_comb begin
        code = C_NOP;
        if (!act_n) begin
            code = C_ACT;
        end else begin
            unique case (ma[16:14])
                3'b000:  code = C_MRS;
                3'b001:  code = C_REF;
                3'b010:  code = C_PRE;
                3'b100:  code = C_WR;
                3'b101:  code = C_RD;
                3'b111:  code = C_NOP;
                default: code = C_OTHER;
            endcase
        end
    end

    assign is_rw   = (code == C_RD) || (code == C_WR);
    assign par_err = par ^ (^{act_n, ma, bg, ba});

    always_comb begin
        err_new = '0;
        if (active) begin
            err_new[0] = par_err;
            err_new[1] = (code == C_ACT) && bank_open[bank];
            err_new[2] = is_rw && !bank_open[bank];
            err_new[3] = is_rw && bank_open[bank] && (timer[bank] != '0);
            err_new[4] = (code == C_REF) && (bank_open != '0);
        end
    end

    always_comb begin
        open_nxt = bank_open;
        for (int i = 0; i < 16; i++) begin
            timer_nxt[i] = (timer[i] != '0) ? timer[i] - 1'b1 : '0;
        end
        if (!dimm_rst_n) begin
            open_nxt = '0;
            for (int i = 0; i < 16; i++) begin
                timer_nxt[i] = '0;
            end
        end else if (active) begin
            if (code == C_ACT) begin
                open_nxt[bank] = 1'b1;
                timer_nxt[bank] = T_LOAD;
            end else if (code == C_PRE) begin
                if (ma[10]) open_nxt = '0;
                else        open_nxt[bank] = 1'b0;
            end else if (is_rw && ma[10]) begin
                open_nxt[bank] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid       <= 1'b0;
            cmd_code        <= '0;
            cmd_bank        <= '0;
            bank_open       <= '0;
            cnt_act         <= '0;
            cnt_rd          <= '0;
            cnt_wr          <= '0;
            cnt_pre         <= '0;
            cnt_ref         <= '0;
            err_flags       <= '0;
            first_err_code  <= '0;
            first_err_bank  <= '0;
            first_err_valid <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                timer[i] <= '0;
            end
        end else begin
            cmd_valid <= active;
            if (active) begin
                cmd_code <= code;
                cmd_bank <= bank;
                if (code == C_ACT) cnt_act <= sat_inc(cnt_act);
                if (code == C_RD)  cnt_rd  <= sat_inc(cnt_rd);
                if (code == C_WR)  cnt_wr  <= sat_inc(cnt_wr);
                if (code == C_PRE) cnt_pre <= sat_inc(cnt_pre);
                if (code == C_REF) cnt_ref <= sat_inc(cnt_ref);
            end
            bank_open <= open_nxt;
            for (int i = 0; i < 16; i++) begin
                timer[i] <= timer_nxt[i];
            end
            err_flags <= err_flags | err_new;
            // capture only the first erroring cycle; frozen until rst_n
            if (!first_err_valid && (err_new != '0)) begin
                first_err_valid <= 1'b1;
                first_err_code  <= code;
                first_err_bank  <= bank;
            end
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_monitor.sv
// Directed self-checking bench for ddr4_cmd_monitor.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_ddr4_cmd_monitor;

    localparam int CNT_W = 4;
    localparam int TRCD  = 8;

    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] ACT = 3'd1;
    localparam logic [2:0] RD  = 3'd2;
    localparam logic [2:0] WR  = 3'd3;
    localparam logic [2:0] PRE = 3'd4;
    localparam logic [2:0] REF = 3'd5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             dimm_rst_n;
    logic             cke;
    logic             cs_n;
    logic             act_n;
    logic [16:0]      ma;
    logic [1:0]       ba;
    logic [1:0]       bg;
    logic             par;
    logic             cmd_valid;
    logic [2:0]       cmd_code;
    logic [3:0]       cmd_bank;
    logic [15:0]      bank_open;
    logic [CNT_W-1:0] cnt_act;
    logic [CNT_W-1:0] cnt_rd;
    logic [CNT_W-1:0] cnt_wr;
    logic [CNT_W-1:0] cnt_pre;
    logic [CNT_W-1:0] cnt_ref;
    logic [4:0]       err_flags;
    logic [2:0]       first_err_code;
    logic [3:0]       first_err_bank;
    logic             first_err_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr4_cmd_monitor #(.CNT_W(CNT_W), .TRCD(TRCD)) dut (
        .clk(clk), .rst_n(rst_n), .dimm_rst_n(dimm_rst_n), .cke(cke),
        .cs_n(cs_n), .act_n(act_n), .ma(ma), .ba(ba), .bg(bg), .par(par),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank),
        .bank_open(bank_open), .cnt_act(cnt_act), .cnt_rd(cnt_rd),
        .cnt_wr(cnt_wr), .cnt_pre(cnt_pre), .cnt_ref(cnt_ref),
        .err_flags(err_flags), .first_err_code(first_err_code),
        .first_err_bank(first_err_bank), .first_err_valid(first_err_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // set up one command on the pins, then advance to the next falling edge
    task automatic put(input logic [2:0] c, input logic [3:0] b,
                       input logic ap, input logic bad_par);
        logic [2:0] rcw;
        cs_n  = 1'b0;
        act_n = (c != ACT);
        case (c)
            RD:      rcw = 3'b101;
            WR:      rcw = 3'b100;
            PRE:     rcw = 3'b010;
            REF:     rcw = 3'b001;
            ACT:     rcw = 3'b011;
            default: rcw = 3'b111;
        endcase
        ma     = '0;
        ma[16:14] = rcw;
        ma[10] = ap;
        ma[3:0] = b;
        {bg, ba} = b;
        par = (^{act_n, ma, bg, ba}) ^ bad_par;
        @(negedge clk);
    endtask

    task automatic idle();
        cs_n  = 1'b1;
        act_n = 1'b1;
        ma    = '1;
        par   = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; dimm_rst_n = 1'b1; cke = 1'b1;
        cs_n = 1'b1; act_n = 1'b1; ma = '1; ba = '0; bg = '0; par = 1'b0;
        @(negedge clk);

        // reset with an ACT on the bus: discarded, everything zero
        put(ACT, 4'd4, 1'b0, 1'b0);
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_open", 32'(bank_open), 0);
        chk("rst_cnt_act", 32'(cnt_act), 0);
        chk("rst_err", 32'(err_flags), 0);
        chk("rst_fev", 32'(first_err_valid), 0);
        rst_n = 1'b1;

        // basic sequence
        put(ACT, 4'd5, 1'b0, 1'b0);
        chk("bas_valid", 32'(cmd_valid), 1);
        chk("bas_code", 32'(cmd_code), 32'(ACT));
        chk("bas_bank", 32'(cmd_bank), 5);
        chk("bas_open", 32'(bank_open), 32'h0020);
        put(NOP, 4'd0, 1'b0, 1'b0);
        chk("nop_valid", 32'(cmd_valid), 1);
        chk("nop_code", 32'(cmd_code), 32'(NOP));
        for (int i = 0; i < 7; i++) put(NOP, 4'd0, 1'b0, 1'b0);
        put(RD, 4'd5, 1'b0, 1'b0);
        put(WR, 4'd5, 1'b1, 1'b0);
        idle();
        chk("bas_idle_valid", 32'(cmd_valid), 0);
        chk("bas_cnt_act", 32'(cnt_act), 1);
        chk("bas_cnt_rd", 32'(cnt_rd), 1);
        chk("bas_cnt_wr", 32'(cnt_wr), 1);
        chk("bas_open_end", 32'(bank_open), 0);
        chk("bas_err", 32'(err_flags), 0);

        // tRCD k=7: violation
        do_reset();
        put(ACT, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) put(NOP, 4'd0, 1'b0, 1'b0);
        put(RD, 4'd3, 1'b0, 1'b0);
        chk("trcd7_err", 32'(err_flags), 32'b01000);
        chk("trcd7_fcode", 32'(first_err_code), 2);
        chk("trcd7_fbank", 32'(first_err_bank), 3);
        chk("trcd7_fvalid", 32'(first_err_valid), 1);

        // tRCD k=8: legal
        do_reset();
        put(ACT, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) put(NOP, 4'd0, 1'b0, 1'b0);
        put(RD, 4'd3, 1'b0, 1'b0);
        chk("trcd8_err", 32'(err_flags), 0);
        chk("trcd8_cnt_rd", 32'(cnt_rd), 1);

        // parity plus RD/WR-to-closed in one cycle
        do_reset();
        put(WR, 4'd0, 1'b0, 1'b1);
        chk("par_err", 32'(err_flags), 32'b00101);
        chk("par_fcode", 32'(first_err_code), 3);
        chk("par_fbank", 32'(first_err_bank), 0);
        chk("par_cnt_wr", 32'(cnt_wr), 1);

        // bank-state violations; first error stays frozen
        do_reset();
        put(ACT, 4'd1, 1'b0, 1'b0);
        put(ACT, 4'd1, 1'b0, 1'b0);
        chk("dact_err", 32'(err_flags), 32'b00010);
        chk("dact_open", 32'(bank_open), 32'h0002);
        put(PRE, 4'd1, 1'b1, 1'b0);
        chk("prea_open", 32'(bank_open), 0);
        put(RD, 4'd1, 1'b0, 1'b0);
        chk("rdcl_err", 32'(err_flags), 32'b00110);
        put(ACT, 4'd2, 1'b0, 1'b0);
        put(REF, 4'd0, 1'b0, 1'b0);
        chk("refop_err", 32'(err_flags), 32'b10110);
        chk("refop_cnt_ref", 32'(cnt_ref), 1);
        chk("refop_cnt_act", 32'(cnt_act), 3);
        chk("frozen_fcode", 32'(first_err_code), 1);
        chk("frozen_fbank", 32'(first_err_bank), 1);

        // gating by cke and dimm_rst_n
        do_reset();
        cke = 1'b0;
        put(ACT, 4'd7, 1'b0, 1'b0);
        chk("cke0_valid", 32'(cmd_valid), 0);
        chk("cke0_cnt_act", 32'(cnt_act), 0);
        cke = 1'b1;
        put(ACT, 4'd7, 1'b0, 1'b0);
        chk("cke1_open", 32'(bank_open), 32'h0080);
        dimm_rst_n = 1'b0;
        put(ACT, 4'd6, 1'b0, 1'b0);
        chk("drst_open", 32'(bank_open), 0);
        chk("drst_valid", 32'(cmd_valid), 0);
        chk("drst_cnt_act", 32'(cnt_act), 1);
        dimm_rst_n = 1'b1;

        // PRE to closed bank, then counter saturation
        do_reset();
        put(PRE, 4'd9, 1'b0, 1'b0);
        chk("pre_closed_err", 32'(err_flags), 0);
        chk("pre_cnt", 32'(cnt_pre), 1);
        for (int i = 0; i < 20; i++) put(REF, 4'd0, 1'b0, 1'b0);
        chk("sat_cnt_ref", 32'(cnt_ref), 15);
        chk("sat_err", 32'(err_flags), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr4_cmd_monitor.md
# ddr4_cmd_monitor

Passive per-channel DDR4 command-bus monitor for the card-level simulation environment. It sits on the address/command pins driven by the FPGA toward one DIMM (channels A–D each get one instance). It decodes every command, tracks per-bank open/closed state, and checks CA parity, bank-state legality and tRCD. It exports saturating command counters and sticky error flags for the test to poll and report.

## Interface

- `CNT_W`, 32: width of each command counter.
- `TRCD`, 8: minimum spacing, in clk cycles, from ACT to RD/WR on the same bank. Must be ≥1.

Ports:

- `clk`, in, 1: DDR4 CK (true phase); all sampling on rising edge.
- `rst_n`, in, 1: monitor reset. Synchronous, active-low.
- `dimm_rst_n`, in, 1: DIMM reset pin.
- `cke`, in, 1: clock enable pin.
- `cs_n`, in, 1: chip select.
- `act_n`, in, 1: activate.
- `ma`, in, 17: address; `ma[16:14]` = RAS/CAS/WE when `act_n`=1; `ma[10]` = AP/all-bank.
- `ba`, in, 2: bank address.
- `bg`, in, 2: bank group.
- `par`, in, 1: CA parity.
- `cmd_valid`, out, 1: one-cycle pulse per decoded command.
- `cmd_code`, out, 3: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6 MRS, 7 OTHER.
- `cmd_bank`, out, 4: `{bg,ba}` of the decoded command.
- `bank_open`, out, 16: open flag per bank, index `{bg,ba}`.
- `cnt_act`, `cnt_rd`, `cnt_wr`, `cnt_pre`, `cnt_ref`, out, CNT_W each: command counts.
- `err_flags`, out, 5: sticky; [0] parity, [1] ACT to open bank, [2] RD/WR to closed bank, [3] tRCD violation, [4] REF with any bank open.
- `first_err_code`, out, 3: `cmd_code` of the first erroring command.
- `first_err_bank`, out, 4: bank of the first erroring command.
- `first_err_valid`, out, 1: first-error capture holds data.

## Operation

- **Active condition:** `rst_n`=1, `dimm_rst_n`=1, `cke`=1 and `cs_n`=0.
  - Outside this condition there is no decode, no count and no check.
  - `dimm_rst_n`=0 clears `bank_open` and all tRCD timers; counters and errors are kept.
- **Decode:**
  - `act_n`=0 → ACT.
  - Otherwise by RAS/CAS/WE: LLL MRS, LLH REF, LHL PRE, HLL WR, HLH RD, HHH NOP. LHH and HHL → OTHER.
- **NOP handling:** `cmd_valid` fires for NOP with cs_n=0; NOP is not counted.
- **Parity:** checked on every active command. Error if `par` ≠ XOR of {`act_n`, `ma[16:0]`, `bg`, `ba`}.
- **Bank state:**
  - ACT sets `bank_open[b]` and loads timer[b] = TRCD−1.
  - PRE with `ma[10]`=0 clears bank b; with `ma[10]`=1 clears all banks.
  - RD/WR with `ma[10]`=1 clears bank b after its checks.
- **Per-bank timer:** each timer decrements by 1 per clk while nonzero, whether or not a command is present.
- **Checks:**
  - ACT to an open bank: err[1] is set, the bank stays open and its timer reloads.
  - RD/WR to a closed bank: err[2] is set and bank state is unchanged.
  - RD/WR to an open bank whose timer ≠0: err[3] is set.
  - REF while `bank_open`≠0: err[4] is set.
  - PRE to a closed bank is legal.
- **Simultaneous errors:** several error bits may set in one cycle; all of them set.
- **First-error capture:** records the first cycle in which any error bit sets. It is frozen afterwards until `rst_n`.
- **Counters:** erroring commands are still counted. Each counter saturates at all-ones and holds there.

## Timing

- Registered outputs. A command sampled on edge n is reflected in every output after edge n+1 (1-cycle latency).
- ACT at sample n followed by RD/WR on the same bank at sample n+k is a tRCD violation iff k < TRCD.
- **Reset values (rst_n=0 at an edge):** all outputs 0. This covers `bank_open`, counters, `err_flags`, the first-error fields and `cmd_valid`; timers are also cleared.
- Reset mid-traffic takes effect on the next edge; the command sampled on that edge is discarded.
- There is no backpressure and no handshake; the monitor must accept a command every cycle.

## Test plan

- **Basic sequence:** reset, then ACT b5, 8 NOPs, RD b5, WR b5 with AP=1.
  - `cnt_act`=1, `cnt_rd`=1, `cnt_wr`=1.
  - `bank_open`=0, `err_flags`=0.
- **tRCD boundary:** ACT b3 then RD b3 at k=7 → err[3]=1, `first_err_code`=2, `first_err_bank`=3.
  - Repeat after reset with k=8 → err[3]=0.
- **Parity error:** drive WR b0 with `par` inverted → err[0]=1.
  - With b0 closed, err[2] also sets in the same cycle and `first_err_code`=3.
- **Bank-state violations:**
  - ACT b1 twice → err[1]=1.
  - PREA then RD b1 → err[2]=1.
  - ACT b2 then REF → err[4]=1 and `cnt_ref`=1.
- **Gating:**
  - ACT b7 with `cke`=0 → no `cmd_valid`, `cnt_act`=0.
  - ACT b7 with `cke`=1, then pulse `dimm_rst_n` low → `bank_open`=0 while `cnt_act`=1 is retained.
- **Saturation:** use CNT_W=4 and issue 20 REFs with no banks open → `cnt_ref`=15 and no errors.
